// File: rtl/input_conditioner_if.sv
// Raw board inputs and their conditioned versions, grouped as one bundle.
// The slave side is the conditioner; the master side is whatever drives the raw pins.
interface input_conditioner_if #(
    parameter int unsigned SW_WIDTH = 8
);
    logic                key_n_in;
    logic [SW_WIDTH-1:0] sw_in;
    logic                key_level;
    logic                key_press_pulse;
    logic                key_release_pulse;
    logic [SW_WIDTH-1:0] sw_out;
    logic                sw_changed;

    modport master (
        output key_n_in,
        output sw_in,
        input  key_level,
        input  key_press_pulse,
        input  key_release_pulse,
        input  sw_out,
        input  sw_changed
    );

    modport slave (
        input  key_n_in,
        input  sw_in,
        output key_level,
        output key_press_pulse,
        output key_release_pulse,
        output sw_out,
        output sw_changed
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchroniser and debouncer for the active-low pushbutton and the slide-switch bus.
// Emits registered clean levels plus one-cycle press/release/change strobes.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SW_WIDTH        = 8
) (
    input logic                 clk,
    input logic                 reset_n,
    input_conditioner_if.slave  cond
);
    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        StStableUp,
        StPendDown,
        StStableDown,
        StPendUp
    } key_state_e;

    logic                key_m, key_s;
    logic [SW_WIDTH-1:0] sw_m, sw_s, sw_p;

    key_state_e          key_state_q, key_state_d;
    logic [CNT_W-1:0]    kcnt_q, kcnt_d;
    logic                key_level_q, key_level_d;
    logic                press_q, press_d;
    logic                release_q, release_d;

    logic [CNT_W-1:0]    scnt_q, scnt_d;
    logic [SW_WIDTH-1:0] sw_out_q, sw_out_d;
    logic                changed_q, changed_d;
    logic                sw_settling;

    // Key syncs reset high so an idle (released) button is never seen as a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_m <= 1'b1;
            key_s <= 1'b1;
            sw_m  <= '0;
            sw_s  <= '0;
            sw_p  <= '0;
        end else begin
            key_m <= cond.key_n_in;
            key_s <= key_m;
            sw_m  <= cond.sw_in;
            sw_s  <= sw_m;
            sw_p  <= sw_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_state_q <= StStableUp;
            kcnt_q      <= '0;
            key_level_q <= 1'b1;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            scnt_q      <= '0;
            sw_out_q    <= '0;
            changed_q   <= 1'b0;
        end else begin
            key_state_q <= key_state_d;
            kcnt_q      <= kcnt_d;
            key_level_q <= key_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            scnt_q      <= scnt_d;
            sw_out_q    <= sw_out_d;
            changed_q   <= changed_d;
        end
    end

    always_comb begin
        key_state_d = key_state_q;
        kcnt_d      = kcnt_q;
        key_level_d = key_level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        unique case (key_state_q)
            StStableUp: begin
                if (!key_s) begin
                    // A single-cycle debounce accepts on the first differing sample.
                    if (DEBOUNCE_CYCLES == 1) begin
                        key_state_d = StStableDown;
                        key_level_d = 1'b0;
                        press_d     = 1'b1;
                        kcnt_d      = '0;
                    end else begin
                        key_state_d = StPendDown;
                        kcnt_d      = CNT_ONE;
                    end
                end
            end
            StPendDown: begin
                if (key_s) begin
                    key_state_d = StStableUp;
                    kcnt_d      = '0;
                end else if (kcnt_q == CNT_LAST) begin
                    key_state_d = StStableDown;
                    key_level_d = 1'b0;
                    press_d     = 1'b1;
                    kcnt_d      = '0;
                end else begin
                    kcnt_d = kcnt_q + CNT_ONE;
                end
            end
            StStableDown: begin
                if (key_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        key_state_d = StStableUp;
                        key_level_d = 1'b1;
                        release_d   = 1'b1;
                        kcnt_d      = '0;
                    end else begin
                        key_state_d = StPendUp;
                        kcnt_d      = CNT_ONE;
                    end
                end
            end
            StPendUp: begin
                if (!key_s) begin
                    key_state_d = StStableDown;
                    kcnt_d      = '0;
                end else if (kcnt_q == CNT_LAST) begin
                    key_state_d = StStableUp;
                    key_level_d = 1'b1;
                    release_d   = 1'b1;
                    kcnt_d      = '0;
                end else begin
                    kcnt_d = kcnt_q + CNT_ONE;
                end
            end
            default: begin
                key_state_d = StStableUp;
                kcnt_d      = '0;
            end
        endcase
    end

    // Count only while the new bus value differs from the accepted one and has stopped moving.
    assign sw_settling = (sw_s != sw_out_q) && (sw_s == sw_p);

    always_comb begin
        scnt_d    = '0;
        sw_out_d  = sw_out_q;
        changed_d = 1'b0;
        if (sw_settling) begin
            if (scnt_q == CNT_LAST) begin
                sw_out_d  = sw_s;
                changed_d = 1'b1;
            end else begin
                scnt_d = scnt_q + CNT_ONE;
            end
        end
    end

    assign cond.key_level         = key_level_q;
    assign cond.key_press_pulse   = press_q;
    assign cond.key_release_pulse = release_q;
    assign cond.sw_out            = sw_out_q;
    assign cond.sw_changed        = changed_q;
endmodule
